dm_sort_checker: RTL and testbench

//  Hardware self-check for CPU_Pipelined runs: reads back a data-memory array once the CPU reaches a halt PC
//  and reports whether it is in ascending order. Sits beside the MEM stage, on a spare synchronous read port
//  of the data memory. Replaces bench-side hierarchical memory inspection with a synthesizable pass/fail.

---
 rtl/dm_sort_checker.sv | 146 ++++++++++++++
 tb/tb_dm_sort_checker.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dm_sort_checker.sv
// ----------------------------------------------------------------------------
// dm_sort_checker : reads back a data-memory array after the CPU halts and
//                   reports whether it is in ascending order.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dm_sort_checker #(
  parameter logic [31:0] BASE_ADDR  = 32'd512,
  parameter int          NUM_WORDS  = 12,
  parameter logic [31:0] HALT_PC    = 32'd88,
  parameter bit          SIGNED_CMP = 1'b1,
  parameter bit          STRICT     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        clear_i,
  output logic        dm_rd_o,
  output logic [31:0] dm_addr_o,
  input  logic [31:0] dm_rdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [15:0] fail_idx_o,
  output logic [15:0] checked_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_CAPT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int          c_last_int = (NUM_WORDS < 2) ? 0 : NUM_WORDS - 1;
  localparam logic [15:0] c_last_idx = c_last_int[15:0];

  logic [1:0]  state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [31:0] prev_q, prev_d;
  logic        pass_q, pass_d;
  logic [15:0] fail_idx_q, fail_idx_d;
  logic [15:0] checked_q, checked_d;
  logic        dm_rd_q;
  logic [31:0] dm_addr_q;
  logic        busy_q, done_q;

  logic w_lt, w_eq, w_ordered;

  assign w_lt      = SIGNED_CMP ? ($signed(prev_q) < $signed(dm_rdata_i)) : (prev_q < dm_rdata_i);
  assign w_eq      = (prev_q == dm_rdata_i);
  assign w_ordered = w_lt || (!STRICT && w_eq);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    prev_d     = prev_q;
    pass_d     = pass_q;
    fail_idx_d = fail_idx_q;
    checked_d  = checked_q;
    case (state_q)
      S_IDLE: begin
        if (pc_i == HALT_PC) begin
          idx_d      = 16'd0;
          checked_d  = 16'd0;
          fail_idx_d = 16'd0;
          pass_d     = 1'b0;
          // Fewer than two elements are trivially ordered; no reads needed.
          if (NUM_WORDS < 2) begin
            state_d = S_DONE;
            pass_d  = 1'b1;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: state_d = S_CAPT;
      S_CAPT: begin
        checked_d = idx_q + 16'd1;
        if (idx_q == 16'd0) begin
          prev_d  = dm_rdata_i;
          idx_d   = 16'd1;
          state_d = S_REQ;
        end else if (!w_ordered) begin
          state_d    = S_DONE;
          pass_d     = 1'b0;
          fail_idx_d = idx_q;
        end else if (idx_q == c_last_idx) begin
          state_d    = S_DONE;
          pass_d     = 1'b1;
          fail_idx_d = 16'd0;
        end else begin
          prev_d  = dm_rdata_i;
          idx_d   = idx_q + 16'd1;
          state_d = S_REQ;
        end
      end
      S_DONE: begin
        if (clear_i) begin
          state_d = S_IDLE;
          pass_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= 16'd0;
      prev_q     <= 32'd0;
      pass_q     <= 1'b0;
      fail_idx_q <= 16'd0;
      checked_q  <= 16'd0;
      dm_rd_q    <= 1'b0;
      dm_addr_q  <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      prev_q     <= prev_d;
      pass_q     <= pass_d;
      fail_idx_q <= fail_idx_d;
      checked_q  <= checked_d;
      dm_rd_q    <= (state_d == S_REQ);
      if (state_d == S_REQ) begin
        dm_addr_q <= BASE_ADDR + {14'd0, idx_d, 2'b00};
      end
      busy_q     <= (state_d == S_REQ) || (state_d == S_CAPT);
      done_q     <= (state_d == S_DONE);
    end
  end

  assign dm_rd_o    = dm_rd_q;
  assign dm_addr_o  = dm_addr_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign pass_o     = pass_q;
  assign fail_idx_o = fail_idx_q;
  assign checked_o  = checked_q;

endmodule

`default_nettype wire

// File: tb/tb_dm_sort_checker.sv
// ----------------------------------------------------------------------------
// tb_dm_sort_checker : scoreboard bench for dm_sort_checker (four parameter sets).
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_dm_sort_checker;

  typedef struct {
    bit pass;
    int fidx;
    int chk;
    int due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic [31:0] pc_v    [4];
  logic        dm_rd_v [4];
  logic [31:0] addr_v  [4];
  logic        busy_v  [4];
  logic        done_v  [4];
  logic        pass_v  [4];
  logic [15:0] fidx_v  [4];
  logic [15:0] chk_v   [4];
  logic [31:0] mem [16];

  exp_t sbq [4][$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   ecyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) ecyc <= ecyc + 1;

  function automatic void chk(string name, int k, longint act, longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0d expected %0d (cycle %0d)", name, k, act, exp, ecyc);
    end
  endfunction

  // u0: defaults; u1: non-strict; u2: 2 words signed; u3: 2 words unsigned
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int NW = (g >= 2) ? 2 : 12;
    localparam bit SC = (g == 3) ? 1'b0 : 1'b1;
    localparam bit ST = (g == 1) ? 1'b0 : 1'b1;

    logic [31:0] rdata = 32'd0;
    logic [31:0] wa;
    int          nrd = 0;
    logic        dprev = 1'b0;

    dm_sort_checker #(
      .BASE_ADDR (32'd512),
      .NUM_WORDS (NW),
      .HALT_PC   (32'd88),
      .SIGNED_CMP(SC),
      .STRICT    (ST)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .pc_i      (pc_v[g]),
      .clear_i   (clear),
      .dm_rd_o   (dm_rd_v[g]),
      .dm_addr_o (addr_v[g]),
      .dm_rdata_i(rdata),
      .busy_o    (busy_v[g]),
      .done_o    (done_v[g]),
      .pass_o    (pass_v[g]),
      .fail_idx_o(fidx_v[g]),
      .checked_o (chk_v[g])
    );

    assign wa = (addr_v[g] - 32'd512) >> 2;

    always @(posedge clk) begin
      if (dm_rd_v[g]) rdata <= (wa < 32'd16) ? mem[wa[3:0]] : 32'hDEAD_BEEF;
      if (rst || done_v[g]) nrd <= 0;
      else if (dm_rd_v[g]) nrd <= nrd + 1;
    end

    always @(negedge clk) begin
      exp_t e;
      if (dm_rd_v[g]) chk("dm_addr", g, addr_v[g], 512 + 4 * nrd);
      if (done_v[g] && !dprev) begin
        if (sbq[g].size() == 0) begin
          chk("unexpected_done", g, 1, 0);
        end else begin
          e = sbq[g].pop_front();
          chk("pass", g, pass_v[g], e.pass);
          chk("fail_idx", g, fidx_v[g], e.fidx);
          chk("checked", g, chk_v[g], e.chk);
          chk("done_cycle", g, ecyc, e.due);
          chk("rd_pulses", g, nrd, e.chk);
          chk("busy_with_done", g, busy_v[g], 0);
        end
      end
      dprev = done_v[g];
    end
  end

  task automatic trig(int k, bit p, int f, int c, int lat, bit hold);
    exp_t e;
    e.pass = p; e.fidx = f; e.chk = c; e.due = ecyc + 1 + lat;
    sbq[k].push_back(e);
    pc_v[k] = 32'd88;
    @(negedge clk);
    if (!hold) pc_v[k] = 32'd0;
  endtask

  task automatic wait_done(int k);
    int n = 0;
    while (!done_v[k] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done_v[k]) chk("done_timeout", k, 0, 1);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset(int k);
    chk("rst_dm_rd", k, dm_rd_v[k], 0);
    chk("rst_addr", k, addr_v[k], 0);
    chk("rst_busy", k, busy_v[k], 0);
    chk("rst_done", k, done_v[k], 0);
    chk("rst_pass", k, pass_v[k], 0);
    chk("rst_fidx", k, fidx_v[k], 0);
    chk("rst_checked", k, chk_v[k], 0);
  endtask

  task automatic load_sorted();
    for (int i = 0; i < 16; i++) mem[i] = 32'(11 * (i + 1));
  endtask

  initial begin
    int t0;
    exp_t e;
    for (int k = 0; k < 4; k++) pc_v[k] = 32'd0;
    load_sorted();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) check_reset(k);
    rst = 1'b0;
    @(negedge clk);

    // Fully sorted array
    trig(0, 1'b1, 0, 12, 24, 1'b0);
    wait_done(0);
    do_clear();

    // Early exit at element 2
    mem[0] = 32'd55; mem[1] = 32'd88; mem[2] = 32'd0; mem[3] = 32'd22;
    trig(0, 1'b0, 2, 3, 6, 1'b0);
    wait_done(0);
    do_clear();

    // Equal neighbours a[5]=a[6]=77: strict fails, non-strict passes
    load_sorted();
    mem[4] = 32'd55; mem[5] = 32'd77; mem[6] = 32'd77; mem[7] = 32'd88;
    trig(0, 1'b0, 6, 7, 14, 1'b0);
    wait_done(0);
    trig(1, 1'b1, 0, 12, 24, 1'b0);
    wait_done(1);
    do_clear();

    // Last element out of order
    load_sorted();
    mem[11] = 32'd5;
    trig(0, 1'b0, 11, 12, 24, 1'b0);
    wait_done(0);
    do_clear();

    // -5, 3: ordered signed, not ordered unsigned
    mem[0] = 32'hFFFF_FFFB; mem[1] = 32'd3;
    trig(2, 1'b1, 0, 2, 4, 1'b0);
    wait_done(2);
    trig(3, 1'b0, 1, 2, 4, 1'b0);
    wait_done(3);
    do_clear();

    // Reset in CAPT with idx=4, then restart with pc held
    load_sorted();
    t0 = ecyc + 1;
    trig(0, 1'b1, 0, 12, 24, 1'b1);
    while (ecyc < t0 + 9) @(negedge clk);
    chk("capt_busy", 0, busy_v[0], 1);
    chk("capt_rd", 0, dm_rd_v[0], 0);
    chk("capt_addr", 0, addr_v[0], 528);
    rst = 1'b1;
    sbq[0].delete();
    @(negedge clk);
    rst = 1'b0;
    check_reset(0);
    trig(0, 1'b1, 0, 12, 24, 1'b0);
    wait_done(0);
    do_clear();

    // Clear with pc held re-runs the scan; clear with pc elsewhere stays idle
    trig(0, 1'b1, 0, 12, 24, 1'b1);
    wait_done(0);
    e.pass = 1'b1; e.fidx = 0; e.chk = 12; e.due = ecyc + 2 + 24;
    sbq[0].push_back(e);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("done_dropped", 0, done_v[0], 0);
    wait_done(0);
    pc_v[0] = 32'd0;
    do_clear();
    repeat (10) begin
      chk("idle_rd", 0, dm_rd_v[0], 0);
      chk("idle_busy", 0, busy_v[0], 0);
      chk("idle_done", 0, done_v[0], 0);
      @(negedge clk);
    end

    for (int k = 0; k < 4; k++) chk("sb_empty", k, sbq[k].size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
